data_memory: RTL and testbench

Word-organized, byte-addressed data memory for the processor's memory stage. It accepts one synchronous word write per clock and provides a combinational word read, both gated by the control unit's `mem_read`/`mem_write` strobes. Contents are cleared by an asynchronous active-low reset, and an error flag marks misaligned or out-of-range accesses.

---
 rtl/data_memory.sv | 47 ++++
 tb/tb_data_memory.sv | 129 ++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-organized, byte-addressed data memory with per-access alignment/range error flag.
// Latency: write commits at the rising edge, read is combinational (0 cycles).
// Backpressure: none; every enabled access completes in its cycle.
module data_memory #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              addr_err
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] upper;
  logic              aligned;
  logic              in_range;
  logic              valid;

  assign idx      = addr[IDX_W+1:2];
  // Anything above the word-index field must be zero for the address to land inside the array.
  assign upper    = addr >> (IDX_W + 2);
  assign aligned  = (addr[1:0] == 2'b00);
  assign in_range = (upper == '0);
  assign valid    = aligned & in_range;

  assign read_data = (mem_read && valid) ? mem[idx] : 32'h0;
  assign addr_err  = (mem_read | mem_write) & ~valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (mem_write && valid) begin
      mem[idx] <= write_data;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus queues expected outputs, a negedge monitor checks them.
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        addr_err;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  data_memory #(.DEPTH(256), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .addr_err   (addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: outputs are combinational, so each queued expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (read_data !== e.rd || addr_err !== e.err) begin
        errors++;
        $display("FAIL %s: read_data=%h addr_err=%b, required read_data=%h addr_err=%b",
                 e.name, read_data, addr_err, e.rd, e.err);
      end
    end
  end

  task automatic cyc(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input string nm,
                     input logic [31:0] erd, input logic eerr);
    @(posedge clk);
    #1;
    mem_read   = rd;
    mem_write  = wr;
    addr       = a;
    write_data = wd;
    exp_q.push_back('{name: nm, rd: erd, err: eerr});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr       = 32'h0;
    write_data = 32'h0;

    cyc(1, 0, 32'h0, 32'h0, "reset_read0", 32'h0, 1'b0);
    cyc(1, 1, 32'h5, 32'hFFFF_FFFF, "reset_err_follows", 32'h0, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    cyc(0, 1, 32'h4, 32'hABCD_1234, "write4", 32'h0, 1'b0);
    cyc(1, 0, 32'h4, 32'h0, "read4", 32'hABCD_1234, 1'b0);
    cyc(0, 1, 32'h8, 32'h5555_5555, "write8", 32'h0, 1'b0);
    cyc(1, 0, 32'h8, 32'h0, "read8", 32'h5555_5555, 1'b0);
    cyc(1, 0, 32'h4, 32'h0, "reread4", 32'hABCD_1234, 1'b0);
    cyc(0, 0, 32'h4, 32'h0, "read_disabled", 32'h0, 1'b0);
    cyc(1, 0, 32'hC, 32'h0, "read_unwritten_c", 32'h0, 1'b0);
    cyc(0, 1, 32'h5, 32'hDEAD_BEEF, "write_misaligned", 32'h0, 1'b1);
    cyc(1, 0, 32'h4, 32'h0, "read4_after_misaligned", 32'hABCD_1234, 1'b0);
    cyc(0, 1, 32'h400, 32'hDEAD_BEEF, "write_oor_400", 32'h0, 1'b1);
    cyc(1, 0, 32'h400, 32'h0, "read_oor_400", 32'h0, 1'b1);
    cyc(0, 1, 32'h404, 32'hDEAD_BEEF, "write_oor_404", 32'h0, 1'b1);
    cyc(1, 0, 32'h4, 32'h0, "read4_after_oor", 32'hABCD_1234, 1'b0);
    cyc(1, 0, 32'h0, 32'h0, "read0_unchanged", 32'h0, 1'b0);
    cyc(0, 1, 32'h3FC, 32'hCAFE_F00D, "write_last_word", 32'h0, 1'b0);
    cyc(1, 0, 32'h3FC, 32'h0, "read_last_word", 32'hCAFE_F00D, 1'b0);
    cyc(1, 1, 32'h8, 32'h1234_5678, "rw_same_before_edge", 32'h5555_5555, 1'b0);
    cyc(1, 0, 32'h8, 32'h0, "rw_same_after_edge", 32'h1234_5678, 1'b0);
    cyc(0, 0, 32'h5, 32'h0, "idle_no_err", 32'h0, 1'b0);
    cyc(1, 0, 32'h4, 32'h0, "read4_pre_reset", 32'hABCD_1234, 1'b0);

    // Reset pulse confined between two rising edges, with the read still enabled.
    @(posedge clk);
    #1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    addr      = 32'h4;
    #2 rst_n  = 1'b0;
    exp_q.push_back('{name: "async_reset_read4", rd: 32'h0, err: 1'b0});
    @(negedge clk);
    #1 rst_n = 1'b1;

    cyc(1, 0, 32'h4, 32'h0, "read4_after_reset", 32'h0, 1'b0);
    cyc(1, 0, 32'h8, 32'h0, "read8_after_reset", 32'h0, 1'b0);
    cyc(1, 0, 32'h3FC, 32'h0, "read_last_after_reset", 32'h0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
